// File: rtl/pq_sreg_dev_if.sv
// Client/device connection for the sorted-shift-register priority queue.
// The client drives the master side; the queue device sits on the slave side.
interface pq_sreg_dev_if #(
   parameter int KEY_W = 16,
   parameter int VAL_W = 16,
   parameter int DEPTH = 16
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [KEY_W-1:0] kvi_key;
   logic [VAL_W-1:0] kvi_val;
   logic             enq;
   logic             deq;
   logic             clr;
   logic [KEY_W-1:0] kvo_key;
   logic [VAL_W-1:0] kvo_val;
   logic             full;
   logic             empty;
   logic             busy;
   logic [CNT_W-1:0] count;
   logic             ovf;
   logic             udf;

   modport master (
      output kvi_key, kvi_val, enq, deq, clr,
      input  kvo_key, kvo_val, full, empty, busy, count, ovf, udf
   );

   modport slave (
      input  kvi_key, kvi_val, enq, deq, clr,
      output kvo_key, kvo_val, full, empty, busy, count, ovf, udf
   );
endinterface

// File: rtl/pq_sreg_dev.sv
// Sorted shift-register priority queue: head at slot 0, FIFO among equal keys.
// Define PQ_MAX_FIRST_EN for max-key-first ordering (default is min-key-first).
module pq_sreg_dev #(
   parameter int KEY_W = 16,
   parameter int VAL_W = 16,
   parameter int DEPTH = 16
) (
   input logic           clk,
   input logic           rst_n,
   pq_sreg_dev_if.slave  pq
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef struct packed {
      logic [KEY_W-1:0] key;
      logic [VAL_W-1:0] val;
   } slot_t;

   typedef enum logic [2:0] {OP_HOLD, OP_CLR, OP_INS, OP_DEQ, OP_REP} op_e;

   function automatic logic beats(input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b);
`ifdef PQ_MAX_FIRST_EN
      return a > b;
`else
      return a < b;
`endif
   endfunction

   slot_t            s_q     [DEPTH];
   slot_t            s_d     [DEPTH];
   slot_t            ins_s   [DEPTH];
   slot_t            rep_s   [DEPTH];
   slot_t            deq_s   [DEPTH];
   slot_t            new_s;
   logic [DEPTH:0]   t;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, udf_q, ovf_set, udf_set;
   logic             is_full, is_empty;
   op_e              op;

   assign new_s    = '{key: pq.kvi_key, val: pq.kvi_val};
   assign is_full  = (count_q == FULL_CNT);
   assign is_empty = (count_q == '0);

   // t[i]: the new entry belongs at or ahead of slot i (strict compare keeps ties FIFO).
   assign t[DEPTH] = 1'b1;

   for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      slot_t above, below;
      logic  t_above;

      assign t[i] = (count_q <= CNT_W'(i)) || beats(pq.kvi_key, s_q[i].key);

      if (i == 0) begin : g_head
         assign above   = new_s;
         assign t_above = 1'b0;
      end else begin : g_body
         assign above   = s_q[i-1];
         assign t_above = t[i-1];
      end

      if (i == DEPTH - 1) begin : g_tail
         assign below = '0;
      end else begin : g_inner
         assign below = s_q[i+1];
      end

      assign ins_s[i] = t[i] ? (t_above ? above : new_s) : s_q[i];
      // Replace sees the queue with the head already gone: slot i compares against s[i+1].
      assign rep_s[i] = t[i+1] ? ((i != 0 && t[i]) ? s_q[i] : new_s) : below;
      assign deq_s[i] = below;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      op      = OP_HOLD;
      ovf_set = 1'b0;
      udf_set = 1'b0;
      if (pq.clr) begin
         op = OP_CLR;
      end else if (pq.enq && pq.deq) begin
         op      = OP_INS;
         udf_set = is_empty;
         if (!is_empty) op = OP_REP;
      end else if (pq.enq) begin
         if (is_full) ovf_set = 1'b1;
         else         op      = OP_INS;
      end else if (pq.deq) begin
         if (is_empty) udf_set = 1'b1;
         else          op      = OP_DEQ;
      end
   end

   always_comb begin
      s_d     = s_q;
      count_d = count_q;
      unique case (op)
         OP_CLR: begin
            for (int i = 0; i < DEPTH; i++) s_d[i] = '0;
            count_d = '0;
         end
         OP_INS: begin
            s_d     = ins_s;
            count_d = count_q + 1'b1;
         end
         OP_DEQ: begin
            s_d     = deq_s;
            count_d = count_q - 1'b1;
         end
         OP_REP:  s_d = rep_s;
         default: ;
      endcase
   end

   // NOTE: storage is reset too, because invalid slots must read as zero and slot 0 drives kvo.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) s_q[i] <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         s_q     <= s_d;
         count_q <= count_d;
         ovf_q   <= ovf_q | ovf_set;
         udf_q   <= udf_q | udf_set;
      end
   end

   assign pq.kvo_key = s_q[0].key;
   assign pq.kvo_val = s_q[0].val;
   assign pq.full    = is_full;
   assign pq.empty   = is_empty;
   assign pq.busy    = 1'b0;
   assign pq.count   = count_q;
   assign pq.ovf     = ovf_q;
   assign pq.udf     = udf_q;
endmodule

// File: tb/tb_pq_sreg_dev.sv
// Self-checking bench for pq_sreg_dev: directed scenarios plus random traffic
// against a queue-based reference model. Honours PQ_MAX_FIRST_EN like the RTL.
module tb_pq_sreg_dev;
   localparam int KEY_W = 16;
   localparam int VAL_W = 16;
   localparam int DEPTH = 16;

   typedef struct {
      int unsigned key;
      int unsigned val;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   ent_t mq[$];
   bit   m_ovf, m_udf;

   pq_sreg_dev_if #(.KEY_W(KEY_W), .VAL_W(VAL_W), .DEPTH(DEPTH)) pq ();
   pq_sreg_dev #(.KEY_W(KEY_W), .VAL_W(VAL_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .pq    (pq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit higher(input int unsigned a, input int unsigned b);
`ifdef PQ_MAX_FIRST_EN
      return a > b;
`else
      return a < b;
`endif
   endfunction

   function automatic void m_insert(input int unsigned key, input int unsigned val);
      int pos = mq.size();
      ent_t e;
      e.key = key;
      e.val = val;
      for (int j = 0; j < mq.size(); j++)
         if (higher(key, mq[j].key)) begin
            pos = j;
            break;
         end
      mq.insert(pos, e);
   endfunction

   function automatic void model(input bit e, input bit d, input bit c, input int unsigned key, input int unsigned val);
      if (c) begin
         mq.delete();
      end else if (e && d) begin
         if (mq.size() == 0) m_udf = 1'b1;
         else void'(mq.pop_front());
         m_insert(key, val);
      end else if (e) begin
         if (mq.size() == DEPTH) m_ovf = 1'b1;
         else m_insert(key, val);
      end else if (d) begin
         if (mq.size() == 0) m_udf = 1'b1;
         else void'(mq.pop_front());
      end
   endfunction

   task automatic check_all(input string tag);
      int unsigned hk = (mq.size() != 0) ? mq[0].key : 0;
      int unsigned hv = (mq.size() != 0) ? mq[0].val : 0;
      check({tag, ".key"},   32'(pq.kvo_key), hk);
      check({tag, ".val"},   32'(pq.kvo_val), hv);
      check({tag, ".count"}, 32'(pq.count), mq.size());
      check({tag, ".empty"}, 32'(pq.empty), 32'(mq.size() == 0));
      check({tag, ".full"},  32'(pq.full), 32'(mq.size() == DEPTH));
      check({tag, ".busy"},  32'(pq.busy), 0);
      check({tag, ".ovf"},   32'(pq.ovf), 32'(m_ovf));
      check({tag, ".udf"},   32'(pq.udf), 32'(m_udf));
   endtask

   task automatic step(input string tag, input bit e, input bit d, input bit c,
                       input int unsigned key, input int unsigned val);
      @(negedge clk);
      pq.enq     = e;
      pq.deq     = d;
      pq.clr     = c;
      pq.kvi_key = KEY_W'(key);
      pq.kvi_val = VAL_W'(val);
      @(posedge clk);
      #1;
      model(e, d, c, key, val);
      check_all(tag);
   endtask

   task automatic idle_inputs();
      pq.enq = 1'b0;
      pq.deq = 1'b0;
      pq.clr = 1'b0;
      pq.kvi_key = '0;
      pq.kvi_val = '0;
   endtask

   task automatic reset_model();
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
   endtask

   task automatic drain(input string tag);
      while (mq.size() != 0) step(tag, 1'b0, 1'b1, 1'b0, 0, 0);
   endtask

   initial begin
      idle_inputs();
      reset_model();
      #12;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Ordering and FIFO tie-break.
      step("t1.e5", 1, 0, 0, 5, 16'h5);
      step("t1.e2a", 1, 0, 0, 2, 16'hA);
      step("t1.e9", 1, 0, 0, 9, 16'h9);
      step("t1.e2b", 1, 0, 0, 2, 16'hB);
`ifndef PQ_MAX_FIRST_EN
      check("t1.head_is_2A", {pq.kvo_key, pq.kvo_val}, {16'd2, 16'hA});
      step("t1.d1", 0, 1, 0, 0, 0);
      check("t1.second_is_2B", {pq.kvo_key, pq.kvo_val}, {16'd2, 16'hB});
`endif
      drain("t1.drain");

      // Full: overflow drops the enqueue, replace still works.
      for (int i = 0; i < DEPTH; i++) step("t2.fill", 1, 0, 0, 10 + i, i);
      step("t2.ovf", 1, 0, 0, 0, 16'hEE);
      step("t2.rep", 1, 1, 0, 0, 16'hEF);
      drain("t2.drain");

      // Empty: underflow flag, then enq+deq on empty is accepted.
      reset_model();
      idle_inputs();
      rst_n = 1'b0;
      #1;
      check_all("t3.rst");
      @(negedge clk);
      rst_n = 1'b1;
      step("t3.udf", 0, 1, 0, 0, 0);
      step("t3.enqdeq_empty", 1, 1, 0, 7, 16'h77);
      drain("t3.drain");

      // Replace with the new key landing mid-queue.
      step("t4.e3", 1, 0, 0, 3, 1);
      step("t4.e4", 1, 0, 0, 4, 2);
      step("t4.e8", 1, 0, 0, 8, 3);
      step("t4.rep6", 1, 1, 0, 6, 4);
      drain("t4.drain");

      // clr ignores a concurrent enq and keeps the sticky flags.
      for (int i = 0; i < 10; i++) step("t5.load", 1, 0, 0, $urandom_range(0, 20), i);
      step("t5.clr", 1, 0, 1, 3, 3);
      for (int i = 0; i < 5; i++) step("t5.reload", 1, 0, 0, $urandom_range(0, 20), i);

      // Asynchronous reset lands between clock edges.
      #2;
      rst_n = 1'b0;
      #1;
      reset_model();
      check_all("t5.async_rst");
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;

      // Random traffic with narrow keys so ties are frequent.
      for (int phase = 0; phase < 6; phase++) begin
         int unsigned pe = (phase % 2 == 0) ? 80 : 30;
         for (int n = 0; n < 300; n++) begin
            bit e = ($urandom_range(0, 99) < pe);
            bit d = ($urandom_range(0, 99) < (100 - pe));
            bit c = ($urandom_range(0, 199) == 0);
            step("rnd", e, d, c, $urandom_range(0, 7), $urandom_range(0, 16'hFFFF));
         end
      end
      drain("rnd.drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
